sequenciador_div_ula: RTL and testbench

- Multi-cycle controller that owns the shared 8-bit ULA (add/sub, zero and negativo flags) and sequences it to perform unsigned division by repeated subtraction.
- Produces a quotient and a remainder.
- While idle, it passes the datapath's ULA request straight through, so the processor keeps normal single-cycle use of the ULA.
- Sits between the processor control/datapath and the single ULA instance.

---
 rtl/sequenciador_div_ula.sv | 115 +++++++++++
 tb/tb_sequenciador_div_ula.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sequenciador_div_ula.sv
// Division sequencer that owns the shared ULA. While idle it forwards the datapath request.
// While busy it runs repeated subtraction to produce an unsigned quotient and remainder.
module sequenciador_div_ula #(
  parameter int                 LARGURA   = 8,
  parameter logic [LARGURA-1:0] QUOC_DIV0 = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inicio,
  input  logic [LARGURA-1:0] dividendo,
  input  logic [LARGURA-1:0] divisor,
  input  logic               ctrl_dp,
  input  logic [LARGURA-1:0] a_dp,
  input  logic [LARGURA-1:0] b_dp,
  input  logic [LARGURA-1:0] saida_ula,
  input  logic               zero,
  input  logic               negativo,
  output logic               controle_ula,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic               ula_livre,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               erro_div0
);

  typedef enum logic [1:0] {OCIOSO, SUBTRAI, FIM} estado_t;

  estado_t            estado, prox_estado;
  logic [LARGURA-1:0] r, d, q;

  assign ocupado   = (estado != OCIOSO);
  assign ula_livre = !ocupado;
  assign pronto    = (estado == FIM);

  // NOTE: state and data registers use non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    prox_estado  = estado;
    controle_ula = 1'b0;
    ula_a        = '0;
    ula_b        = '0;
    unique case (estado)
      OCIOSO: begin
        controle_ula = ctrl_dp;
        ula_a        = a_dp;
        ula_b        = b_dp;
        if (inicio) prox_estado = (divisor == '0) ? FIM : SUBTRAI;
      end
      SUBTRAI: begin
        controle_ula = 1'b1;
        ula_a        = r;
        ula_b        = d;
        if (negativo || zero) prox_estado = FIM;
      end
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  // Result registers load on the edge that enters FIM, so they are valid with pronto.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r         <= '0;
      d         <= '0;
      q         <= '0;
      quociente <= '0;
      resto     <= '0;
      erro_div0 <= 1'b0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (inicio) begin
            r <= dividendo;
            d <= divisor;
            q <= '0;
            if (divisor == '0) begin
              quociente <= QUOC_DIV0;
              resto     <= dividendo;
              erro_div0 <= 1'b1;
            end
          end
        end
        SUBTRAI: begin
          if (negativo) begin
            quociente <= q;
            resto     <= r;
            erro_div0 <= 1'b0;
          end else if (zero) begin
            // Exact division: the final subtraction is counted and r clears.
            r         <= '0;
            q         <= q + 1'b1;
            quociente <= q + 1'b1;
            resto     <= '0;
            erro_div0 <= 1'b0;
          end else begin
            r <= saida_ula;
            q <= q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_div_ula.sv
// Directed bench for sequenciador_div_ula; the shared ULA is modelled here combinationally.
module tb_sequenciador_div_ula;

  logic       clk = 1'b0;
  logic       reset, inicio, ctrl_dp, zero, negativo;
  logic [7:0] dividendo, divisor, a_dp, b_dp, saida_ula;
  logic       controle_ula, ula_livre, ocupado, pronto, erro_div0;
  logic [7:0] ula_a, ula_b, quociente, resto;

  int n_checks = 0;
  int n_errors = 0;

  sequenciador_div_ula #(.LARGURA(8), .QUOC_DIV0(8'hFF)) dut (
    .clk(clk), .reset(reset), .inicio(inicio),
    .dividendo(dividendo), .divisor(divisor),
    .ctrl_dp(ctrl_dp), .a_dp(a_dp), .b_dp(b_dp),
    .saida_ula(saida_ula), .zero(zero), .negativo(negativo),
    .controle_ula(controle_ula), .ula_a(ula_a), .ula_b(ula_b),
    .ula_livre(ula_livre), .ocupado(ocupado), .pronto(pronto),
    .quociente(quociente), .resto(resto), .erro_div0(erro_div0)
  );

  always #5 clk = ~clk;

  // Reference ULA: add/sub with zero and borrow flags.
  assign saida_ula = controle_ula ? (ula_a - ula_b) : (ula_a + ula_b);
  assign zero      = (saida_ula == 8'h00);
  assign negativo  = controle_ula && (ula_b > ula_a);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                         input bit reinject, input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_e, input int exp_lat);
    int lat;
    bit livre_ok;
    @(negedge clk);
    dividendo = dvd;
    divisor   = dvs;
    inicio    = 1'b1;
    @(posedge clk);
    #1;
    lat      = 1;
    livre_ok = 1'b1;
    if (reinject) begin
      dividendo = 8'd50;
      divisor   = 8'd1;
    end else begin
      inicio = 1'b0;
    end
    if (dvs != 8'd0) begin
      a_dp    = 8'hAA;
      b_dp    = 8'h55;
      ctrl_dp = 1'b0;
      #1;
      check({tag, " sub ula_a"}, ula_a, dvd);
      check({tag, " sub ula_b"}, ula_b, dvs);
      check({tag, " sub ctrl"}, controle_ula, 1'b1);
    end
    while (!pronto && lat < 400) begin
      if (ula_livre !== 1'b0 || ocupado !== 1'b1) livre_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy during op"}, livre_ok, 1'b1);
    check({tag, " quociente"}, quociente, exp_q);
    check({tag, " resto"}, resto, exp_r);
    check({tag, " erro_div0"}, erro_div0, exp_e);
    check({tag, " fim ula idle"}, {controle_ula, ula_a, ula_b, ula_livre}, 18'h0);
    @(posedge clk);
    #1;
    inicio = 1'b0;
    check({tag, " pronto one cycle"}, {pronto, ocupado, ula_livre}, 3'b001);
    check({tag, " quociente hold"}, quociente, exp_q);
    check({tag, " resto hold"}, resto, exp_r);
  endtask

  initial begin
    reset     = 1'b1;
    inicio    = 1'b0;
    dividendo = '0;
    divisor   = '0;
    ctrl_dp   = 1'b0;
    a_dp      = '0;
    b_dp      = '0;
    #12;
    check("reset outputs", {ocupado, pronto, erro_div0, quociente, resto}, 19'h0);
    check("reset ula_livre", ula_livre, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    ctrl_dp = 1'b1;
    a_dp    = 8'h0F;
    b_dp    = 8'h01;
    #1;
    check("idle pass ula_a", ula_a, 8'h0F);
    check("idle pass ula_b", ula_b, 8'h01);
    check("idle pass ctrl", controle_ula, 1'b1);
    check("idle pass saida", saida_ula, 8'h0E);

    run_div("13/4", 8'd13, 8'd4, 1'b0, 8'd3, 8'd1, 1'b0, 5);
    run_div("12/4", 8'd12, 8'd4, 1'b0, 8'd3, 8'd0, 1'b0, 4);
    run_div("255/1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0, 256);
    run_div("0/5", 8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0, 2);
    run_div("20/6 reinicio", 8'd20, 8'd6, 1'b1, 8'd3, 8'd2, 1'b0, 5);
    run_div("7/0", 8'd7, 8'd0, 1'b0, 8'hFF, 8'd7, 1'b1, 1);

    // Reset during the second subtraction cycle of 200/3.
    @(negedge clk);
    dividendo = 8'd200;
    divisor   = 8'd3;
    inicio    = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    @(posedge clk);
    #1;
    check("200/3 busy before reset", ocupado, 1'b1);
    a_dp  = 8'h33;
    reset = 1'b1;
    #1;
    check("reset mid outputs", {ocupado, pronto, erro_div0, quociente, resto}, 19'h0);
    check("reset mid ula_livre", ula_livre, 1'b1);
    check("reset mid pass ula_a", ula_a, 8'h33);
    @(negedge clk);
    reset = 1'b0;

    run_div("9/3", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
